// File: rtl/regfile_read_arbiter_if.sv
// Handshake bundle between the requester/read-mux side and the read-port arbiter.
// master: requesters plus the register-file mux; slave: the arbiter.
interface regfile_read_arbiter_if #(
    parameter int NREQ   = 4,
    parameter int DATA_W = 64,
    parameter int ADDR_W = 5
);
    logic [NREQ-1:0]             req;
    logic [NREQ-1:0][ADDR_W-1:0] addr;
    logic [NREQ-1:0]             gnt;
    logic [ADDR_W-1:0]           sel;
    logic [DATA_W-1:0]           regData;
    logic [DATA_W-1:0]           rdData;
    logic [NREQ-1:0]             rdValid;
    logic                        busy;

    modport master (
        output req, addr, regData,
        input  gnt, sel, rdData, rdValid, busy
    );

    modport slave (
        input  req, addr, regData,
        output gnt, sel, rdData, rdValid, busy
    );
endinterface

// File: rtl/regfile_read_arbiter.sv
// Round-robin sequencer sharing one register-file read port among NREQ requesters.
// Optional RF_READ_XZR_EN: reads of index 31 return zero (XZR).
module regfile_read_arbiter #(
    parameter int NREQ   = 4,
    parameter int DATA_W = 64,
    parameter int ADDR_W = 5
) (
    input logic                    clk,
    input logic                    reset,
    regfile_read_arbiter_if.slave  bus
);
    localparam int OW = $clog2(NREQ);

    typedef enum logic {IDLE = 1'b0, READ = 1'b1} state_e;

    state_e              state_q, state_d;
    logic [OW-1:0]       owner_q, owner_d;
    logic [OW-1:0]       last_q, last_d;
    logic [NREQ-1:0]     gnt_q, gnt_d;
    logic [ADDR_W-1:0]   sel_q, sel_d;
    logic [DATA_W-1:0]   rdData_q, rdData_d;
    logic [NREQ-1:0]     rdValid_q, rdValid_d;
    logic                any_req;
    logic [OW-1:0]       win;

    // Scan downward so the closest index after last overwrites the rest.
    always_comb begin
        any_req = |bus.req;
        win     = '0;
        for (int k = NREQ; k >= 1; k--) begin
            if (bus.req[(int'(last_q) + k) % NREQ]) begin
                win = OW'((int'(last_q) + k) % NREQ);
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        last_d    = last_q;
        gnt_d     = '0;
        sel_d     = sel_q;
        rdData_d  = rdData_q;
        rdValid_d = '0;
        if (state_q == READ) begin
            rdValid_d[owner_q] = 1'b1;
`ifdef RF_READ_XZR_EN
            rdData_d = (sel_q == {ADDR_W{1'b1}}) ? '0 : bus.regData;
`else
            rdData_d = bus.regData;
`endif
        end
        if (any_req) begin
            state_d    = READ;
            gnt_d[win] = 1'b1;
            sel_d      = bus.addr[win];
            owner_d    = win;
            last_d     = win;
        end else begin
            state_d = IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            owner_q   <= '0;
            last_q    <= OW'(NREQ - 1);
            gnt_q     <= '0;
            sel_q     <= '0;
            rdData_q  <= '0;
            rdValid_q <= '0;
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            last_q    <= last_d;
            gnt_q     <= gnt_d;
            sel_q     <= sel_d;
            rdData_q  <= rdData_d;
            rdValid_q <= rdValid_d;
        end
    end

    assign bus.gnt     = gnt_q;
    assign bus.sel     = sel_q;
    assign bus.rdData  = rdData_q;
    assign bus.rdValid = rdValid_q;
    assign bus.busy    = (state_q == READ);
endmodule

// File: tb/tb_regfile_read_arbiter.sv
// Directed and random bench for regfile_read_arbiter against a transaction-level model.
// The register file is modelled as regData = sel * 64'h0101 unless a value is forced.
module tb_regfile_read_arbiter;
    localparam int NREQ   = 4;
    localparam int DATA_W = 64;
    localparam int ADDR_W = 5;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic force_en = 1'b0;
    logic [63:0] force_val = 64'hDEAD_BEEF_CAFE_F00D;

    int checks = 0;
    int passed = 0;

    regfile_read_arbiter_if #(.NREQ(NREQ), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

    regfile_read_arbiter #(.NREQ(NREQ), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] mux_model(input logic [4:0] s);
        return force_en ? force_val : 64'(s) * 64'h0101;
    endfunction

    assign bus.regData = mux_model(bus.sel);

    // Reference model: transaction-level view of the arbiter.
    int          m_last  = NREQ - 1;
    bit          m_read  = 0;
    int          m_owner = 0;
    logic [4:0]  m_sel   = '0;
    logic [63:0] m_data  = '0;
    logic [3:0]  m_gnt   = '0;
    logic [3:0]  m_vld   = '0;

    function automatic int rr_winner(input logic [3:0] r, input int last);
        for (int k = 1; k <= NREQ; k++) begin
            if (r[(last + k) % NREQ]) return (last + k) % NREQ;
        end
        return -1;
    endfunction

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        checks++;
        assert (got === exp) passed++;
        else $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    endtask

    task automatic step();
        int w;
        bit xzr;
        logic [3:0] nv;
        logic [63:0] nd;
        xzr = 1'b0;
`ifdef RF_READ_XZR_EN
        xzr = 1'b1;
`endif
        nv = '0;
        nd = m_data;
        if (m_read) begin
            nv[m_owner] = 1'b1;
            nd = (xzr && m_sel == 5'd31) ? 64'd0 : mux_model(m_sel);
        end
        w = rr_winner(bus.req, m_last);
        @(posedge clk);
        #1;
        if (reset) begin
            m_last = NREQ - 1; m_read = 0; m_owner = 0;
            m_sel = '0; m_data = '0; m_gnt = '0; m_vld = '0;
        end else begin
            m_vld  = nv;
            m_data = nd;
            if (w >= 0) begin
                m_gnt = 4'(1 << w);
                m_sel = bus.addr[w];
                m_owner = w;
                m_last = w;
                m_read = 1;
            end else begin
                m_gnt = '0;
                m_read = 0;
            end
        end
        chk("gnt", 64'(bus.gnt), 64'(m_gnt));
        chk("sel", 64'(bus.sel), 64'(m_sel));
        chk("rdData", bus.rdData, m_data);
        chk("rdValid", 64'(bus.rdValid), 64'(m_vld));
        chk("busy", 64'(bus.busy), 64'(m_read));
    endtask

    initial begin
        bus.req  = '1;
        bus.addr = '{5'd3, 5'd2, 5'd1, 5'd0};

        // Reset held with every request up
        reset = 1'b1;
        repeat (3) step();
        chk("rst_gnt", 64'(bus.gnt), 64'd0);
        chk("rst_busy", 64'(bus.busy), 64'd0);

        reset = 1'b0;
        step();
        chk("first_gnt", 64'(bus.gnt), 64'h1);
        bus.req = '0;
        step();
        step();

        // Single read from requester 2
        bus.req = 4'b0100;
        bus.addr[2] = 5'd5;
        step();
        chk("single_gnt", 64'(bus.gnt), 64'h4);
        chk("single_sel", 64'(bus.sel), 64'd5);
        bus.req = '0;
        step();
        chk("single_data", bus.rdData, 64'h0505);
        chk("single_vld", 64'(bus.rdValid), 64'h4);
        chk("single_busy", 64'(bus.busy), 64'd0);

        // Wrap past last=2, then requester 1 withdraws
        bus.req = 4'b1010;
        step();
        chk("wrap_gnt", 64'(bus.gnt), 64'h8);
        bus.req = '0;
        step();
        chk("wd_gnt", 64'(bus.gnt), 64'd0);
        step();
        chk("wd_vld", 64'(bus.rdValid), 64'd0);

        // Contention from a fresh reset
        reset = 1'b1;
        step();
        reset = 1'b0;
        bus.req = '1;
        for (int i = 0; i < 8; i++) begin
            step();
            chk("cont_gnt", 64'(bus.gnt), 64'(1 << (i % 4)));
            if (i > 0) chk("cont_vld", 64'(bus.rdValid), 64'(1 << ((i - 1) % 4)));
        end
        bus.req = '0;
        step();
        step();

        // Index 31 with a forced mux value
        bus.req = 4'b0001;
        bus.addr[0] = 5'd31;
        step();
        force_en = 1'b1;
        bus.req = '0;
        step();
`ifdef RF_READ_XZR_EN
        chk("xzr_data", bus.rdData, 64'd0);
`else
        chk("xzr_data", bus.rdData, force_val);
`endif
        force_en = 1'b0;
        step();

        // Reset lands during READ
        bus.req = 4'b0100;
        step();
        reset = 1'b1;
        bus.req = '0;
        step();
        chk("abort_vld", 64'(bus.rdValid), 64'd0);
        chk("abort_busy", 64'(bus.busy), 64'd0);
        reset = 1'b0;
        bus.req = '1;
        step();
        chk("abort_gnt", 64'(bus.gnt), 64'h1);

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            bus.req = 4'($urandom);
            for (int j = 0; j < NREQ; j++) begin
                bus.addr[j] = ($urandom_range(0, 3) == 0) ? 5'd31 : 5'($urandom);
            end
            force_en  = ($urandom_range(0, 4) == 0);
            force_val = {$urandom, $urandom};
            reset     = ($urandom_range(0, 39) == 0);
            step();
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule

// File: doc/regfile_read_arbiter.md
# regfile_read_arbiter

Round-robin arbiter and sequencer that shares one 32×64 register-file read port among `NREQ` requesters. It sits between the requesters (decode, debug and forwarding-check units) and the register-file 32:1 read mux. It drives the mux select from the winning requester's address and registers the mux output. It returns the data with a one-hot valid tagged to the owning requester.

## Interface

**Parameters**
- `NREQ`, default 4: number of requesters, 2..8.
- `DATA_W`, default 64: read-data width.
- `ADDR_W`, default 5: register index width (32 registers).

**Ports**
- `clk`  in  1  rising-edge clock.
- `reset`  in  1  synchronous, active-high reset.
- `req`  in  `NREQ`  per-requester read request, level.
- `addr`  in  `[NREQ-1:0][ADDR_W-1:0]`  per-requester register index.
- `gnt`  out  `NREQ`  one-hot grant, registered, one-cycle pulse.
- `sel`  out  `ADDR_W`  registered select to the read mux.
- `regData`  in  `DATA_W`  combinational read-mux output for `sel`.
- `rdData`  out  `DATA_W`  registered read data.
- `rdValid`  out  `NREQ`  one-hot, one-cycle pulse marking `rdData` owner.
- `busy`  out  1  high while in READ.

## Operation

**States**
- IDLE and READ, encoded in 1 bit.
- `owner` register, `log2(NREQ)` bits: requester served in READ.
- `last` register: most recent grant. Reset value is `NREQ-1`, so requester 0 has first priority.

**Arbitration**
- Evaluated every cycle in both states.
- The winner is the first asserted `req[i]` scanning `last+1, last+2, …`, wrapping modulo `NREQ`.

**IDLE**
- No `req` asserted: stay in IDLE.
- Any `req` asserted, winner `w`: at the edge, `gnt[w]<=1`, `sel<=addr[w]`, `owner<=w`, `last<=w`, next state READ.

**READ** (mux settling on `sel`)
- At the edge, always: `rdData<=regData` and `rdValid[owner]<=1`.
- If any `req` is asserted: grant the new winner exactly as from IDLE and stay in READ (back-to-back).
- Otherwise: next state IDLE, `gnt<=0`.

**Requester rules**
- Drop `req` the cycle after seeing `gnt`. A held `req` is treated as a new request and competes under round-robin.
- Deasserting `req` before it is granted withdraws the request; no `gnt` is issued.
- `addr` only needs to be valid in the cycle in which `req` wins.

**Arithmetic and values**
- `sel` and `rdData` are pass-through; no arithmetic beyond the round-robin modulo wrap.
- `gnt` and `rdValid` are never multi-hot.

**Reset**
- Reset values: state=IDLE, `gnt=0`, `sel=0`, `rdData=0`, `rdValid=0`, `busy=0`, `owner=0`, `last=NREQ-1`.
- Reset asserted mid-READ aborts the in-flight read: no `rdValid` is issued and the data is lost. Reset has priority over all transitions.

## Timing

**Latency**
- `req` sampled high at edge E0 gives `gnt` high during cycle E0→E1.
- `rdData` and `rdValid` are high during cycle E1→E2.
- Total: request to data is 2 edges.

**Throughput**
- One read per cycle under continuous contention.
- `gnt` for read k+1 coincides with `rdValid` for read k.

**Flags and combinational paths**
- `busy` equals (state==READ).
- The only combinational path is `sel`→external mux→`regData`→`rdData` flop. `regData` must settle within one cycle.

## Configuration

- Macro: `RF_READ_XZR_EN`.
- **Defined:** a grant whose `addr` is 31 captures `rdData<=0` in READ, regardless of `regData` (LEGv8 XZR semantics). `sel` is still driven to 31.
- **Undefined:** `rdData` always equals `regData` for the granted index.

## Test plan

- **Reset values.** Hold `reset` 3 cycles with all `req` high → every output at its reset value. The first grant after release goes to requester 0.
- **Single read.** `req[2]=1` with `addr[2]=5` for one cycle; model `regData = sel*64'h0101` → `gnt=4'b0100` at +1, `sel=5`. At +2, `rdData=64'h0505` and `rdValid=4'b0100`. `busy` falls at +2.
- **Contention.** All four `req` held high for 8 cycles → grants 0,1,2,3,0,1,2,3 on consecutive cycles. `rdValid` follows the same order one cycle later.
- **Withdrawal and wrap.** `req[3]` and `req[1]` raised together after `last=2` → 3 granted first, then 1. `req[1]` dropped before its grant → no `gnt[1]` and no `rdValid[1]`.
- **XZR.** `addr[0]=31` with `regData` forced to `64'hDEAD…`: with `RF_READ_XZR_EN`, `rdData=0`; without it, `rdData` equals the forced value.
- **Reset mid-op.** Assert `reset` in the READ cycle → no `rdValid` the next cycle. State returns to IDLE and `last` returns to `NREQ-1`.
